// File: rtl/mii_lane_monitor.sv
// rtl/mii_lane_monitor.sv - transmit-lane monitor: frame length, inter-packet gap and control-code checks
// Watches one DATA_WIDTH word per clock, lane 0 being the lowest byte and the first on the wire.
module mii_lane_monitor #(
   parameter int         LANES      = 8,
   parameter int         DATA_WIDTH = 8*LANES,
   parameter int         CTRL_WIDTH = LANES,
   parameter logic [7:0] IDLE_CODE  = 8'h07,
   parameter logic [7:0] START_CODE = 8'hFB,
   parameter logic [7:0] TERM_CODE  = 8'hFD,
   parameter int         MIN_LEN    = 71,
   parameter int         MAX_LEN    = 1525,
   parameter int         MIN_IPG    = 12,
   parameter int         MAX_IPG    = 0,
   parameter int         CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   input  logic [CTRL_WIDTH-1:0] i_tx_ctrl,
   input  logic                  i_clr,
   output logic                  o_frame_done,
   output logic [15:0]           o_frame_len,
   output logic                  o_len_err,
   output logic                  o_ipg_err,
   output logic                  o_align_err,
   output logic                  o_ctrl_err,
   output logic [CNT_W-1:0]      o_frame_cnt,
   output logic [CNT_W-1:0]      o_err_cnt
);
   localparam int          TW        = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [15:0] L_LANES   = 16'(LANES);
   localparam logic [15:0] L_MIN_LEN = 16'(MIN_LEN);
   localparam logic [15:0] L_MAX_LEN = 16'(MAX_LEN);
   localparam logic [15:0] L_MIN_IPG = 16'(MIN_IPG);
   localparam logic [15:0] L_MAX_IPG = 16'(MAX_IPG);

   typedef enum logic [1:0] {S_WAIT = 2'd0, S_FRAME = 2'd1, S_GAP = 2'd2} state_t;

   state_t             r_state;
   logic [15:0]        r_len, r_gap, r_frame_len;
   logic               r_done, r_len_err, r_ipg_err, r_align_err, r_ctrl_err;
   logic [CNT_W-1:0]   r_frame_cnt, r_err_cnt;

   logic [LANES-1:0]   w_term, w_start, w_idle, w_ctl, w_below, w_above;
   logic               w_term_found;
   logic [TW-1:0]      w_term_lane;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign w_ctl[k]   = i_tx_ctrl[k];
      assign w_term[k]  = i_tx_ctrl[k] && (i_tx_data[8*k +: 8] == TERM_CODE);
      assign w_start[k] = i_tx_ctrl[k] && (i_tx_data[8*k +: 8] == START_CODE);
      assign w_idle[k]  = i_tx_ctrl[k] && (i_tx_data[8*k +: 8] == IDLE_CODE);
   end

   // Lowest TERM wins; w_below covers the frame bytes, w_above the tail that must be IDLE.
   always_comb begin
      w_term_found = 1'b0;
      w_term_lane  = '0;
      w_below      = '0;
      w_above      = '0;
      for (int k = 0; k < LANES; k++) begin
         if (w_term_found) begin
            w_above[k] = 1'b1;
         end else if (w_term[k]) begin
            w_term_found = 1'b1;
            w_term_lane  = TW'(k);
         end else begin
            w_below[k] = 1'b1;
         end
      end
   end

   logic        w_start0, w_content_err, w_tail_err, w_gap_err, w_align_err;
   logic [16:0] w_len_add, w_gap_add;
   logic [15:0] w_len_sum, w_gap_sum, w_term_gap;

   assign w_start0      = w_start[0];
   assign w_content_err = |(w_below & w_ctl & ~w_start);
   assign w_tail_err    = |(w_above & ~w_idle);
   assign w_gap_err     = |(~w_idle & ~w_start);
   assign w_align_err   = |(w_start >> 1);
   assign w_len_add     = {1'b0, r_len} + (w_term_found ? 17'(w_term_lane) : 17'(LANES));
   assign w_len_sum     = w_len_add[16] ? 16'hFFFF : w_len_add[15:0];
   assign w_gap_add     = {1'b0, r_gap} + 17'(LANES);
   assign w_gap_sum     = w_gap_add[16] ? 16'hFFFF : w_gap_add[15:0];
   assign w_term_gap    = L_LANES - 16'(w_term_lane);

   state_t      w_nxt_state;
   logic [15:0] w_nxt_len, w_nxt_gap, w_fin_len;
   logic        w_begin, w_done, w_ipg_err, w_ctrl_err, w_len_err, w_any_err;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_len   = r_len;
      w_nxt_gap   = r_gap;
      w_fin_len   = r_frame_len;
      w_begin     = 1'b0;
      w_done      = 1'b0;
      w_ipg_err   = 1'b0;
      w_ctrl_err  = 1'b0;
      case (r_state)
         S_WAIT: w_begin = w_start0;
         S_FRAME: begin
            if (w_start0) begin
               w_begin    = 1'b1;
               w_ctrl_err = 1'b1;
            end else if (w_term_found) begin
               w_done      = 1'b1;
               w_fin_len   = w_len_sum;
               w_nxt_state = S_GAP;
               w_nxt_gap   = w_term_gap;
               w_nxt_len   = '0;
               w_ctrl_err  = w_content_err | w_tail_err;
            end else begin
               w_nxt_len  = w_len_sum;
               w_ctrl_err = w_content_err;
            end
         end
         S_GAP: begin
            if (w_start0) begin
               w_begin   = 1'b1;
               w_ipg_err = (r_gap < L_MIN_IPG) || ((MAX_IPG != 0) && (r_gap > L_MAX_IPG));
            end else begin
               w_nxt_gap  = w_gap_sum;
               w_ctrl_err = w_gap_err;
            end
         end
         default: w_nxt_state = S_WAIT;
      endcase
      // A START word may also carry the TERM of a very short frame.
      if (w_begin) begin
         w_ctrl_err = w_ctrl_err | w_content_err;
         if (w_term_found) begin
            w_done      = 1'b1;
            w_fin_len   = 16'(w_term_lane) - 16'd1;
            w_nxt_state = S_GAP;
            w_nxt_gap   = w_term_gap;
            w_nxt_len   = '0;
            w_ctrl_err  = w_ctrl_err | w_tail_err;
         end else begin
            w_nxt_state = S_FRAME;
            w_nxt_len   = L_LANES - 16'd1;
         end
      end
   end

   assign w_len_err = w_done && ((w_fin_len < L_MIN_LEN) || (w_fin_len > L_MAX_LEN));
   assign w_any_err = w_len_err | w_ipg_err | w_align_err | w_ctrl_err;

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_WAIT;
         r_len       <= '0;
         r_gap       <= '0;
         r_frame_len <= '0;
         r_done      <= 1'b0;
         r_len_err   <= 1'b0;
         r_ipg_err   <= 1'b0;
         r_align_err <= 1'b0;
         r_ctrl_err  <= 1'b0;
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_state     <= w_nxt_state;
         r_len       <= w_nxt_len;
         r_gap       <= w_nxt_gap;
         r_frame_len <= w_fin_len;
         r_done      <= w_done;
         r_len_err   <= w_len_err;
         r_ipg_err   <= w_ipg_err;
         r_align_err <= w_align_err;
         r_ctrl_err  <= w_ctrl_err;
         if (i_clr)
            r_frame_cnt <= '0;
         else if (w_done && (r_frame_cnt != '1))
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
         if (i_clr)
            r_err_cnt <= '0;
         else if (w_any_err && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   assign o_frame_done = r_done;
   assign o_frame_len  = r_frame_len;
   assign o_len_err    = r_len_err;
   assign o_ipg_err    = r_ipg_err;
   assign o_align_err  = r_align_err;
   assign o_ctrl_err   = r_ctrl_err;
   assign o_frame_cnt  = r_frame_cnt;
   assign o_err_cnt    = r_err_cnt;
endmodule

// File: doc/mii_lane_monitor.md
MII_LANE_MONITOR -- requirements
Module: mii_lane_monitor

Interface
REQ-001 Parameters (name, default, meaning): LANES, 8, byte lanes per word (8/16/32); DATA_WIDTH, 8*LANES; CTRL_WIDTH, LANES; IDLE_CODE, 8'h07; START_CODE, 8'hFB; TERM_CODE, 8'hFD; MIN_LEN, 71, minimum frame bytes; MAX_LEN, 1525, maximum frame bytes; MIN_IPG, 12; MAX_IPG, 0 (0 = upper gap check disabled); CNT_W, 32, statistics counter width.
REQ-002 Ports (name, direction, width, meaning): clk in 1, sole clock; i_rst in 1, asynchronous active-high reset; i_tx_data in DATA_WIDTH, lane k = bits [8k+7:8k]; i_tx_ctrl in CTRL_WIDTH, bit k marks lane k as control; i_clr in 1, synchronous statistics clear; o_frame_done out 1; o_frame_len out 16; o_len_err out 1; o_ipg_err out 1; o_align_err out 1; o_ctrl_err out 1; o_frame_cnt out CNT_W; o_err_cnt out CNT_W.

Function
REQ-003 Lane k control byte = (i_tx_ctrl[k]==1); lane scans run lowest lane first; first TERM found wins.
REQ-004 States: WAIT_START (post-reset), IN_FRAME, IN_GAP.
REQ-005 START accepted only in lane 0 with ctrl set; START in lanes 1..LANES-1 -> o_align_err, ignored, no state change.
REQ-006 WAIT_START: lane-0 START -> IN_FRAME, length = LANES-1; no IPG check on the first frame after reset.
REQ-007 Frame length = bytes strictly between START and TERM; each non-TERM IN_FRAME word adds LANES; TERM in lane t adds t.
REQ-008 Length accumulator 16-bit, saturates at 16'hFFFF.
REQ-009 IN_FRAME, TERM in lane t -> IN_GAP; gap count = LANES - t (TERM byte counts as gap).
REQ-010 TERM in the START word (lane t >= 1) -> length t-1, same transition as REQ-009.
REQ-011 Lanes above TERM in the same word must be control IDLE; otherwise o_ctrl_err; the frame still completes.
REQ-012 IN_FRAME control byte that is neither TERM nor START -> o_ctrl_err; frame continues and the byte counts toward length.
REQ-013 IN_FRAME lane-0 START -> o_ctrl_err; current frame abandoned (no o_frame_done); new frame begins with length LANES-1.
REQ-014 Frame completion -> o_frame_done for 1 cycle, o_frame_len = final length; o_len_err with it if length < MIN_LEN or > MAX_LEN.
REQ-015 IN_GAP: word without START adds LANES to the gap count (saturating 16-bit); a data lane (ctrl=0) or a control non-IDLE non-START lane -> o_ctrl_err.
REQ-016 IN_GAP lane-0 START -> IN_FRAME; o_ipg_err if gap < MIN_IPG, or MAX_IPG != 0 and gap > MAX_IPG; new frame always accepted.
REQ-017 All outputs registered; each event pulse asserts exactly 1 cycle, the cycle after the word carrying the event is sampled; several pulses may assert together.
REQ-018 o_frame_cnt +1 per o_frame_done; o_err_cnt +1 per cycle in which any error pulse asserts (once per cycle, not per error); both saturate at all-ones.
REQ-019 i_clr zeroes both counters next cycle; clear wins over a simultaneous increment; FSM and length/gap counts unaffected.
REQ-020 o_frame_len holds its value until the next o_frame_done.

Reset
REQ-021 i_rst asserted (any time, including mid-frame): state WAIT_START; length and gap counts 0; every output 0; takes effect immediately without clk.
REQ-022 After i_rst deasserts, the first clk edge samples normally; a frame cut by reset is never reported.

Verification (LANES=8)
REQ-023 START word (lane0 FB, preamble), 8 data words, TERM lane 0 with lanes 1-7 IDLE -> o_frame_done, o_frame_len=71, no errors, o_frame_cnt=1.
REQ-024 After REQ-023, one all-IDLE word, then START -> gap 16, no o_ipg_err; TERM in lane 4 followed directly by a START word -> gap 4, o_ipg_err=1, o_err_cnt+1.
REQ-025 START in lane 3 while in WAIT_START -> o_align_err=1, state stays WAIT_START.
REQ-026 Frame of length 40 -> o_len_err=1 with o_frame_done, o_frame_len=40; lane 6 = 8'h00 (ctrl=1) after TERM -> o_ctrl_err=1.
REQ-027 Assert i_rst mid-frame -> all outputs 0 immediately; next full frame reports correct length, no o_ipg_err.
REQ-028 Counter preloaded near all-ones -> saturates at all-ones; i_clr together with o_frame_done -> o_frame_cnt=0.
